// File: rtl/eth_tx_sched.sv
// Transmit scheduler for a shared GMII port: arbitrates ARP replies, ARP requests and UDP
// frames, enforces the inter-frame gap, retries ARP resolution and guards against stuck transmitters.
module eth_tx_sched #(
  parameter int IFG_CYCLES = 12,
  parameter int ARP_WAIT   = 1250000,
  parameter int ARP_RETRY  = 3,
  parameter int TX_WDOG    = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arp_rx_done,
  input  logic       arp_rx_type,
  input  logic       udp_tx_req,
  input  logic       arp_tx_done,
  input  logic       udp_tx_done,
  output logic       arp_tx_en,
  output logic       arp_tx_type,
  output logic       udp_tx_start_en,
  input  logic       arp_gmii_tx_en,
  input  logic [7:0] arp_gmii_txd,
  input  logic       udp_gmii_tx_en,
  input  logic [7:0] udp_gmii_txd,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       peer_valid,
  output logic       busy,
  output logic       udp_drop,
  output logic       tx_err
);
  localparam int RETRY_W = $clog2(ARP_RETRY + 1);
  localparam int WAIT_W  = $clog2(ARP_WAIT + 1);
  localparam int WDOG_W  = $clog2(TX_WDOG + 1);
  localparam int IFG_W   = $clog2(IFG_CYCLES + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(ARP_RETRY);
  localparam logic [WAIT_W-1:0]  WAIT_LOAD = WAIT_W'(ARP_WAIT);
  localparam logic [WDOG_W-1:0]  WDOG_MAX  = WDOG_W'(TX_WDOG - 1);
  localparam logic [IFG_W-1:0]   IFG_MAX   = IFG_W'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARP_TX = 2'd1, UDP_TX = 2'd2, IFG = 2'd3} state_t;

  state_t               r_state, w_next;
  logic                 r_rep_pend, r_udp_pend, r_peer_valid, r_arp_type, r_sel;
  logic                 r_arp_tx_en, r_udp_start, r_udp_drop, r_tx_err;
  logic [RETRY_W-1:0]   r_retry_cnt;
  logic [WAIT_W-1:0]    r_wait;
  logic [WDOG_W-1:0]    r_wdog;
  logic [IFG_W-1:0]     r_ifg_cnt;
  logic                 r_gmii_tx_en_p1;
  logic [7:0]           r_gmii_txd_p1;

  logic                 w_rep_pend, w_udp_pend, w_peer;
  logic                 w_go_arp, w_go_type, w_go_udp, w_wdog_exp, w_wait_exp, w_drop;
  logic                 w_src_en;
  logic [7:0]           w_src_txd;

  // Requests arriving this cycle are visible to the IDLE arbiter without waiting a cycle.
  assign w_rep_pend = r_rep_pend | (arp_rx_done & ~arp_rx_type);
  assign w_udp_pend = r_udp_pend | udp_tx_req;
  assign w_peer     = r_peer_valid | arp_rx_done;
  assign w_wait_exp = (r_wait == WAIT_W'(1)) & ~arp_rx_done;
  assign w_drop     = w_wait_exp & (r_retry_cnt == RETRY_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_go_arp   = 1'b0;
    w_go_type  = 1'b0;
    w_go_udp   = 1'b0;
    w_wdog_exp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rep_pend) begin
          w_next    = ARP_TX;
          w_go_arp  = 1'b1;
          w_go_type = 1'b1;
        end else if (w_udp_pend && w_peer) begin
          w_next   = UDP_TX;
          w_go_udp = 1'b1;
        end else if (w_udp_pend && (r_wait == '0) && (r_retry_cnt < RETRY_MAX)) begin
          w_next   = ARP_TX;
          w_go_arp = 1'b1;
        end
      end
      ARP_TX: begin
        if (arp_tx_done) w_next = IFG;
        else if (r_wdog == WDOG_MAX) begin
          w_next     = IFG;
          w_wdog_exp = 1'b1;
        end
      end
      UDP_TX: begin
        if (udp_tx_done) w_next = IFG;
        else if (r_wdog == WDOG_MAX) begin
          w_next     = IFG;
          w_wdog_exp = 1'b1;
        end
      end
      IFG: begin
        if (r_ifg_cnt == IFG_MAX) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != IDLE);
    arp_tx_type = (r_state == ARP_TX) & r_arp_type;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep_pend   <= 1'b0;
      r_udp_pend   <= 1'b0;
      r_peer_valid <= 1'b0;
      r_arp_type   <= 1'b0;
      r_sel        <= 1'b0;
      r_arp_tx_en  <= 1'b0;
      r_udp_start  <= 1'b0;
      r_udp_drop   <= 1'b0;
      r_tx_err     <= 1'b0;
      r_retry_cnt  <= '0;
      r_wait       <= '0;
      r_wdog       <= '0;
      r_ifg_cnt    <= '0;
    end else begin
      r_arp_tx_en <= w_go_arp;
      r_udp_start <= w_go_udp;
      r_tx_err    <= w_wdog_exp;
      r_udp_drop  <= w_drop;
      if (arp_rx_done) r_peer_valid <= 1'b1;

      if (w_go_arp && w_go_type)            r_rep_pend <= 1'b0;
      else if (arp_rx_done && !arp_rx_type) r_rep_pend <= 1'b1;

      if (w_go_udp || w_drop) r_udp_pend <= 1'b0;
      else if (udp_tx_req)    r_udp_pend <= 1'b1;

      if (w_go_udp || w_drop)         r_retry_cnt <= '0;
      else if (w_go_arp && !w_go_type) r_retry_cnt <= r_retry_cnt + 1'b1;

      // A learned peer cancels any outstanding ARP reply wait.
      if (arp_rx_done)                                          r_wait <= '0;
      else if ((r_state == ARP_TX) && arp_tx_done && !r_arp_type) r_wait <= WAIT_LOAD;
      else if (r_wait != '0)                                    r_wait <= r_wait - 1'b1;

      if (w_go_arp) begin
        r_arp_type <= w_go_type;
        r_sel      <= 1'b0;
      end else if (w_go_udp) begin
        r_sel      <= 1'b1;
      end

      if (((r_state == ARP_TX) || (r_state == UDP_TX)) && (w_next == r_state))
        r_wdog <= r_wdog + 1'b1;
      else
        r_wdog <= '0;

      if ((r_state == IFG) && (w_next == IFG)) r_ifg_cnt <= r_ifg_cnt + 1'b1;
      else                                     r_ifg_cnt <= '0;
    end
  end

  // Source mux: select stays put through IFG so trailing bytes of the last frame drain.
  assign w_src_en  = r_sel ? udp_gmii_tx_en : arp_gmii_tx_en;
  assign w_src_txd = r_sel ? udp_gmii_txd   : arp_gmii_txd;

  // Stage p1: registered GMII output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gmii_tx_en_p1 <= 1'b0;
      r_gmii_txd_p1   <= 8'h00;
    end else begin
      r_gmii_tx_en_p1 <= w_src_en;
      r_gmii_txd_p1   <= w_src_en ? w_src_txd : 8'h00;
    end
  end

  assign arp_tx_en       = r_arp_tx_en;
  assign udp_tx_start_en = r_udp_start;
  assign udp_drop        = r_udp_drop;
  assign tx_err          = r_tx_err;
  assign peer_valid      = r_peer_valid;
  assign gmii_tx_en      = r_gmii_tx_en_p1;
  assign gmii_txd        = r_gmii_txd_p1;
endmodule

// File: doc/eth_tx_sched.md
ETH_TX_SCHED -- requirements
Module: eth_tx_sched

Interface
REQ-001 The block SHALL have parameter IFG_CYCLES, default 12: idle cycles enforced between consecutive frames.
REQ-002 The block SHALL have parameter ARP_WAIT, default 1250000: cycles to wait for an ARP reply after sending an ARP request.
REQ-003 The block SHALL have parameter ARP_RETRY, default 3: maximum ARP requests per pending UDP send.
REQ-004 The block SHALL have parameter TX_WDOG, default 4096: maximum cycles a transmitter may stay busy without asserting done.
REQ-005 The block SHALL have one clock and an asynchronous active-high reset: clk in 1, GMII TX clock; rst in 1, asynchronous active-high reset.
REQ-006 The block SHALL have these inputs: arp_rx_done in 1 (ARP frame received pulse); arp_rx_type in 1 (0 request, 1 reply); udp_tx_req in 1 (application send pulse); arp_tx_done in 1; udp_tx_done in 1.
REQ-007 The block SHALL have these outputs: arp_tx_en out 1; arp_tx_type out 1; udp_tx_start_en out 1.
REQ-008 The block SHALL have these frame inputs: arp_gmii_tx_en in 1; arp_gmii_txd in 8; udp_gmii_tx_en in 1; udp_gmii_txd in 8.
REQ-009 The block SHALL have these frame outputs: gmii_tx_en out 1; gmii_txd out 8.
REQ-010 The block SHALL have these status outputs: peer_valid out 1 (peer MAC/IP learned); busy out 1 (state not IDLE); udp_drop out 1 (pulse); tx_err out 1 (pulse).

Function
REQ-011 The FSM SHALL have exactly these states: IDLE, ARP_TX, UDP_TX, IFG.
REQ-012 A cycle with arp_rx_done=1 and arp_rx_type=0 SHALL set rep_pend; arp_rx_done=1 of either type SHALL set peer_valid, which SHALL stay set until rst.
REQ-013 udp_tx_req=1 SHALL set udp_pend; a further udp_tx_req while udp_pend=1 SHALL merge into it, not be counted.
REQ-014 In IDLE, the highest-priority ready job SHALL be chosen on the next edge:
- (a) rep_pend: go to ARP_TX with type 1.
- (b) udp_pend and peer_valid: go to UDP_TX.
- (c) udp_pend, peer_valid=0, wait timer idle, retry_cnt<ARP_RETRY: go to ARP_TX with type 0.
- Otherwise stay in IDLE.
REQ-015 On entry to ARP_TX, arp_tx_en SHALL pulse for exactly one cycle; arp_tx_type SHALL be held through ARP_TX.
- rep_pend SHALL clear on entry for type 1.
- For type 0, retry_cnt SHALL increment on entry.
REQ-016 On entry to UDP_TX, udp_tx_start_en SHALL pulse for exactly one cycle; udp_pend and retry_cnt SHALL clear on entry.
REQ-017 ARP_TX SHALL go to IFG on arp_tx_done; UDP_TX SHALL go to IFG on udp_tx_done.
- A done pulse outside the matching state SHALL be ignored.
REQ-018 In ARP_TX and UDP_TX the watchdog SHALL count from 0; if it reaches TX_WDOG-1 without done, the FSM SHALL go to IFG and pulse tx_err for one cycle.
REQ-019 IFG SHALL last exactly IFG_CYCLES cycles, then the FSM SHALL return to IDLE; new requests arriving meanwhile SHALL be latched, not lost.
REQ-020 The wait timer SHALL load ARP_WAIT when arp_tx_done ends a type-0 frame, and SHALL count down in every state.
- It SHALL clear immediately when peer_valid sets.
- On expiry with retry_cnt=ARP_RETRY, udp_pend and retry_cnt SHALL clear and udp_drop SHALL pulse for one cycle.
REQ-021 A source select register SHALL load 0 (ARP) on entry to ARP_TX and 1 (UDP) on entry to UDP_TX, and SHALL hold through IFG so trailing bytes pass.
REQ-022 Each cycle: gmii_tx_en SHALL register the selected source's tx_en; gmii_txd SHALL register the selected txd when that tx_en=1, else 8'h00. The path SHALL have one-cycle latency.
REQ-023 When arp_rx_done and udp_tx_req arrive in the same cycle, both SHALL be latched and the ARP reply SHALL be sent first.

Reset
REQ-024 While rst=1, asynchronously:
- State SHALL be IDLE and the select register 0.
- rep_pend, udp_pend, peer_valid, retry_cnt, the wait timer, the watchdog and the IFG counter SHALL clear.
- All outputs SHALL be 0, including gmii_txd=8'h00.
REQ-025 rst asserted mid-frame SHALL force gmii_tx_en=0 within the same cycle and discard every pending job.

Verification
REQ-026 Scenario: arp_rx_done with type 0 in IDLE -> next cycle ARP_TX with one arp_tx_en pulse and arp_tx_type=1; arp_tx_done -> exactly 12 IFG cycles, then IDLE.
REQ-027 Scenario: udp_tx_req with peer_valid=0, ARP_WAIT=100, no replies -> 3 type-0 requests spaced by at least 100 cycles, then one udp_drop pulse and no udp_tx_start_en.
REQ-028 Scenario: udp_tx_req, then an ARP reply 50 cycles after the request frame -> peer_valid=1 and UDP_TX entered, with exactly one udp_tx_start_en pulse.
REQ-029 Scenario: same-cycle ARP request and udp_tx_req with peer_valid=1 -> ARP reply frame, 12 IFG cycles, then UDP frame; gmii_txd follows each source byte-exact with 1-cycle delay.
REQ-030 Scenario: UDP_TX entered with udp_tx_done never asserted and TX_WDOG=64 -> tx_err pulses at cycle 64, then IFG, then IDLE.
REQ-031 Scenario: rst pulsed during a UDP frame -> gmii_tx_en=0 in the same cycle and peer_valid=0; after release the block stays in IDLE with no request.
